turbo_intlv_addr_gen: RTL

Address sequencer that drives the read port of the interleaver permutation ROM in the HPGP turbo RX path. The ROM's pattern table is selected at build time. The sequencer walks the linear index 0..blk_len-1 into the ROM and captures the permuted index it returns one cycle later. It then presents each (linear, permuted) pair downstream over a valid/ready stream that tolerates backpressure. It sits between the turbo decoder control (start/length) and the LLR buffer address muxes.

---
 rtl/turbo_intlv_addr_gen_if.sv | 36 +++
 rtl/turbo_intlv_addr_gen.sv | 202 ++++++++++++++++++++
 2 files changed

// File: rtl/turbo_intlv_addr_gen_if.sv
// -----------------------------------------------------------------------------
// turbo_intlv_addr_gen_if
//   Bus bundle for the interleaver address sequencer: the read port toward the
//   permutation ROM and the (linear, permuted) output stream toward the LLR
//   buffer address muxes.
//
//   ren / raddr / rdata                      ROM read port (rdata registered in the ROM)
//   out_valid / out_ready                    stream handshake
//   out_seq / out_idx / out_last             stream payload
//
//   master : sequencer side
//   slave  : ROM + downstream consumer side
// -----------------------------------------------------------------------------
interface turbo_intlv_addr_gen_if #(
  parameter int A_WIDTH = 11,
  parameter int D_WIDTH = 11
) ();
  logic               ren;
  logic [A_WIDTH-1:0] raddr;
  logic [D_WIDTH-1:0] rdata;
  logic               out_valid;
  logic               out_ready;
  logic [A_WIDTH-1:0] out_seq;
  logic [D_WIDTH-1:0] out_idx;
  logic               out_last;

  modport master (
    output ren, raddr, out_valid, out_seq, out_idx, out_last,
    input  rdata, out_ready
  );

  modport slave (
    input  ren, raddr, out_valid, out_seq, out_idx, out_last,
    output rdata, out_ready
  );
endinterface

// File: rtl/turbo_intlv_addr_gen.sv
// -----------------------------------------------------------------------------
// turbo_intlv_addr_gen
//   Walks the linear index 0..blk_len-1 into the interleaver permutation ROM,
//   captures the permuted index returned one cycle later and presents each
//   (linear, permuted) pair on a valid/ready stream with backpressure.
//
// Ports
//   clk       in   clock, rising edge
//   n_rst     in   synchronous active-low reset
//   start     in   one-cycle block request (honoured only in IDLE)
//   blk_len   in   block length, 1..2**A_WIDTH, sampled with an accepted start
//   bypass    in   (INTLV_BYPASS_EN only) out_idx = linear index, no ROM reads
//   busy      out  high in RUN and DRAIN
//   done      out  one-cycle pulse after the last pair is accepted
//   len_err   out  one-cycle pulse when start is rejected for a bad length
//   bus       ROM read port + output stream (turbo_intlv_addr_gen_if.master)
//
// Build option
//   INTLV_BYPASS_EN : adds the bypass port and the identity-permutation path.
//
// States
//   IDLE  | waiting for start; length checked here
//   RUN   | issuing ROM reads while the 2-entry output FIFO has credit
//   DRAIN | all reads issued; waiting for the last pair to be accepted
// -----------------------------------------------------------------------------
module turbo_intlv_addr_gen #(
  parameter int A_WIDTH = 11,
  parameter int D_WIDTH = 11
) (
  input  logic                   clk,
  input  logic                   n_rst,
  input  logic                   start,
  input  logic [A_WIDTH:0]       blk_len,
`ifdef INTLV_BYPASS_EN
  input  logic                   bypass,
`endif
  output logic                   busy,
  output logic                   done,
  output logic                   len_err,
  turbo_intlv_addr_gen_if.master bus
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    RUN   = 2'd1,
    DRAIN = 2'd2
  } state_t;

  localparam logic [A_WIDTH:0]   MAX_LEN = {1'b1, {A_WIDTH{1'b0}}};
  localparam logic [A_WIDTH-1:0] ONE_A   = A_WIDTH'(1);

  state_t             state, next_state;
  logic [A_WIDTH-1:0] issue_cnt;
  logic [A_WIDTH-1:0] last_idx;
  logic [A_WIDTH-1:0] seq_d;
  logic               inflight;
  logic [1:0]         fifo_cnt;
  logic               wr_ptr, rd_ptr;
  logic [A_WIDTH-1:0] mem_seq  [2];
  logic [D_WIDTH-1:0] mem_idx  [2];
  logic               mem_last [2];

  logic               len_ok;
  logic               accept;
  logic               issue;
  logic               credit;
  logic               pop;
  logic               wr;
  logic               byp_act;
  logic [2:0]         occ;
  logic [A_WIDTH-1:0] wr_seq;
  logic [D_WIDTH-1:0] wr_idx;

  assign len_ok = (blk_len != '0) && (blk_len <= MAX_LEN);
  assign pop    = bus.out_valid && bus.out_ready;

  // A new read may be issued only if, after this cycle's pop, the FIFO plus
  // the read already in flight leaves a free slot for it.
  assign occ    = {1'b0, fifo_cnt} + {2'b00, inflight};
  assign credit = pop ? (occ < 3'd3) : (occ < 3'd2);

`ifdef INTLV_BYPASS_EN
  logic byp_q;

  always_ff @(posedge clk) begin
    if (!n_rst) begin
      byp_q <= 1'b0;
    end else if (accept) begin
      byp_q <= bypass;
    end
  end

  // In bypass the pair is known at issue time, so it skips the ROM cycle.
  assign byp_act = byp_q;
  assign wr      = inflight || (issue && byp_q);
  assign wr_seq  = byp_q ? issue_cnt : seq_d;
  assign wr_idx  = byp_q ? D_WIDTH'(issue_cnt) : bus.rdata;
`else
  assign byp_act = 1'b0;
  assign wr      = inflight;
  assign wr_seq  = seq_d;
  assign wr_idx  = bus.rdata;
`endif

  always_ff @(posedge clk) begin
    if (!n_rst) begin
      state <= IDLE;
    end else begin
      state <= next_state;
    end
  end

  always_comb begin
    next_state = state;
    accept     = 1'b0;
    issue      = 1'b0;
    case (state)
      IDLE: begin
        if (start && len_ok) begin
          accept     = 1'b1;
          next_state = RUN;
        end
      end
      RUN: begin
        if (credit) begin
          issue = 1'b1;
          if (issue_cnt == last_idx) begin
            next_state = DRAIN;
          end
        end
      end
      DRAIN: begin
        if (pop && bus.out_last) begin
          next_state = IDLE;
        end
      end
      default: next_state = IDLE;
    endcase
  end

  assign bus.ren       = issue && !byp_act;
  assign bus.raddr     = issue_cnt;
  assign busy          = (state != IDLE);
  assign bus.out_valid = (fifo_cnt != 2'd0);
  assign bus.out_seq   = mem_seq[rd_ptr];
  assign bus.out_idx   = mem_idx[rd_ptr];
  assign bus.out_last  = mem_last[rd_ptr];

  always_ff @(posedge clk) begin
    if (!n_rst) begin
      issue_cnt <= '0;
      last_idx  <= '0;
      seq_d     <= '0;
      inflight  <= 1'b0;
      fifo_cnt  <= 2'd0;
      wr_ptr    <= 1'b0;
      rd_ptr    <= 1'b0;
      done      <= 1'b0;
      len_err   <= 1'b0;
      for (int i = 0; i < 2; i++) begin
        mem_seq[i]  <= '0;
        mem_idx[i]  <= '0;
        mem_last[i] <= 1'b0;
      end
    end else begin
      done     <= (state == DRAIN) && pop && bus.out_last;
      len_err  <= (state == IDLE) && start && !len_ok;
      inflight <= bus.ren;

      if (bus.ren) begin
        seq_d <= issue_cnt;
      end

      // blk_len == 2**A_WIDTH has zero low bits; the wrap gives the all-ones
      // last index, which is what we want.
      if (accept) begin
        issue_cnt <= '0;
        last_idx  <= blk_len[A_WIDTH-1:0] - ONE_A;
      end else if (issue) begin
        issue_cnt <= issue_cnt + ONE_A;
      end

      if (wr) begin
        mem_seq[wr_ptr]  <= wr_seq;
        mem_idx[wr_ptr]  <= wr_idx;
        mem_last[wr_ptr] <= (wr_seq == last_idx);
        wr_ptr           <= ~wr_ptr;
      end

      if (pop) begin
        rd_ptr <= ~rd_ptr;
      end

      case ({wr, pop})
        2'b10:   fifo_cnt <= fifo_cnt + 2'd1;
        2'b01:   fifo_cnt <= fifo_cnt - 2'd1;
        default: fifo_cnt <= fifo_cnt;
      endcase
    end
  end

endmodule
